hilo_unit: RTL and testbench

Multiply/divide back-end and HI/LO register pair for the MIPS pipeline EX stage. It sits directly downstream of the combinational Multiplier: it captures the product that block produces, runs DIV/DIVU iteratively, and handles MTHI/MTLO. HI/LO are held for MFHI/MFLO, and `busy` stalls the pipeline while a divide is in flight.

---
 rtl/hilo_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_hilo_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Multiply/divide back-end and HI/LO register pair for the EX stage.
// - MULT/MULTU capture the product halves from the upstream combinational
//   multiplier on the issue edge.
// - MTHI/MTLO load HI or LO from operandA on the issue edge.
// - DIV/DIVU run a restoring divider, one quotient bit per cycle, MSB first,
//   then a FIXUP cycle applies signs and writes LO=quotient, HI=remainder.
// - A zero divisor skips the iterations and writes LO=all ones, HI=operandA.
//
// Ports
//   clock     in   rising-edge clock
//   resetN    in   asynchronous active-low reset
//   start     in   issue strobe (ignored while busy)
//   op        in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                  110/111 no-op
//   operandA  in   rs value: dividend, or MTHI/MTLO source
//   operandB  in   rt value: divisor
//   multHigh  in   upper product half from the multiplier
//   multLow   in   lower product half from the multiplier
//   flush     in   abort an in-flight divide (no effect when idle)
//   hi, lo    out  HI/LO registers
//   busy      out  divide in flight (registered)
//   done      out  one-cycle pulse after a divide result is written (registered)
// -----------------------------------------------------------------------------
module hilo_unit #(
   parameter int nrOfBits = 32
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic                start,
   input  logic [2:0]          op,
   input  logic [nrOfBits-1:0] operandA,
   input  logic [nrOfBits-1:0] operandB,
   input  logic [nrOfBits-1:0] multHigh,
   input  logic [nrOfBits-1:0] multLow,
   input  logic                flush,
   output logic [nrOfBits-1:0] hi,
   output logic [nrOfBits-1:0] lo,
   output logic                busy,
   output logic                done
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int               CNT_W    = $clog2(nrOfBits + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(nrOfBits);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      FIXUP
   } state_t;

   state_t state, state_next;

   // dvd_q starts as the dividend magnitude; quotient bits shift in at the
   // bottom while dividend bits leave at the top, so after nrOfBits
   // iterations it holds the quotient magnitude.
   logic [nrOfBits-1:0] dvd_q;
   logic [nrOfBits-1:0] divisor;
   logic [nrOfBits-1:0] rem;
   logic [CNT_W-1:0]    cnt;
   logic                q_neg;
   logic                r_neg;

   // Issue-side decode
   logic                is_div;
   logic                is_signed;
   logic                divisor_zero;
   logic                a_neg;
   logic                b_neg;
   logic [nrOfBits-1:0] a_mag;
   logic [nrOfBits-1:0] b_mag;

   // Iteration and fixup datapath
   logic [nrOfBits:0]   rem_shift;
   logic                rem_ge;
   logic [nrOfBits-1:0] rem_next;
   logic [nrOfBits-1:0] quot_fix;
   logic [nrOfBits-1:0] rem_fix;

   assign is_div       = (op == OP_DIV) || (op == OP_DIVU);
   assign is_signed    = (op == OP_DIV);
   assign divisor_zero = (operandB == '0);
   assign a_neg        = is_signed && operandA[nrOfBits-1];
   assign b_neg        = is_signed && operandB[nrOfBits-1];
   // Negating the most-negative value wraps back to itself, which is the
   // correct unsigned magnitude 2^(nrOfBits-1).
   assign a_mag        = a_neg ? -operandA : operandA;
   assign b_mag        = b_neg ? -operandB : operandB;

   // The partial remainder stays below the divisor, so the shifted value
   // needs one extra bit; compare and subtract at that width.
   assign rem_shift = {rem, dvd_q[nrOfBits-1]};
   assign rem_ge    = rem_shift >= {1'b0, divisor};
   assign rem_next  = rem_ge ? nrOfBits'(rem_shift - {1'b0, divisor})
                             : rem_shift[nrOfBits-1:0];

   // Negating zero yields zero, so a zero remainder stays zero.
   assign quot_fix = q_neg ? -dvd_q : dvd_q;
   assign rem_fix  = r_neg ? -rem   : rem;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assigned first so every path drives state_next; a path
      // that left it unassigned would infer a latch.
      state_next = state;
      case (state)
         IDLE: begin
            if (start && is_div) begin
               state_next = divisor_zero ? FIXUP : DIVIDE;
            end
         end
         DIVIDE: begin
            if (flush) begin
               state_next = IDLE;
            end else if (cnt == CNT_ONE) begin
               state_next = FIXUP;
            end
         end
         FIXUP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // HI/LO, divider datapath and registered status outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dvd_q   <= '0;
         divisor <= '0;
         rem     <= '0;
         cnt     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register in this block
         // samples the pre-edge values, independent of statement order.
         busy <= (state_next != IDLE);
         done <= (state == FIXUP) && !flush;

         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        hi <= multHigh;
                        lo <= multLow;
                     end
                     OP_MTHI: hi <= operandA;
                     OP_MTLO: lo <= operandA;
                     OP_DIV, OP_DIVU: begin
                        if (divisor_zero) begin
                           // Forced result flows through FIXUP unchanged.
                           dvd_q <= '1;
                           rem   <= operandA;
                           q_neg <= 1'b0;
                           r_neg <= 1'b0;
                        end else begin
                           dvd_q   <= a_mag;
                           divisor <= b_mag;
                           rem     <= '0;
                           cnt     <= CNT_INIT;
                           q_neg   <= a_neg ^ b_neg;
                           r_neg   <= a_neg;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            DIVIDE: begin
               if (!flush) begin
                  rem   <= rem_next;
                  dvd_q <= {dvd_q[nrOfBits-2:0], rem_ge};
                  cnt   <= cnt - CNT_ONE;
               end
            end
            FIXUP: begin
               if (!flush) begin
                  lo <= quot_fix;
                  hi <= rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit (nrOfBits = 32): a table of directed
// vectors, hand-written multi-cycle sequences (flush, flush vs. FIXUP,
// back-to-back divide, async reset mid-divide) and a randomized run against a
// behavioural HI/LO model built from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP6  = 3'b110;
   localparam int         DIV_LAT  = 33;

   logic        clock;
   logic        resetN;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic [31:0] multHigh;
   logic [31:0] multLow;
   logic        flush;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int total;
   int bad;

   hilo_unit #(.nrOfBits(32)) dut (
      .clock    (clock),
      .resetN   (resetN),
      .start    (start),
      .op       (op),
      .operandA (operandA),
      .operandB (operandB),
      .multHigh (multHigh),
      .multLow  (multLow),
      .flush    (flush),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] mh;
      logic [31:0] ml;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven and
   // outputs sampled there, well away from the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] mh, input logic [31:0] ml, input logic fl);
      op       = o;
      operandA = a;
      operandB = b;
      multHigh = mh;
      multLow  = ml;
      flush    = fl;
      start    = 1'b1;
      step();
      start    = 1'b0;
      flush    = 1'b0;
   endtask

   // Called right after the issue edge; counts edges until done shows up,
   // with busy required high on every cycle before it.
   task automatic wait_done(input string name, input int exp_lat);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         check({name, "_busy"}, {31'b0, busy}, 32'd1);
         step();
         n++;
      end
      check({name, "_latency"}, n, exp_lat);
      check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic apply(input vec_t v);
      issue(v.op, v.a, v.b, v.mh, v.ml, 1'b0);
      if (v.lat == 0) begin
         check({v.name, "_busy"}, {31'b0, busy}, 32'd0);
         check({v.name, "_done"}, {31'b0, done}, 32'd0);
      end else begin
         wait_done(v.name, v.lat);
      end
      check({v.name, "_hi"}, hi, v.exp_hi);
      check({v.name, "_lo"}, lo, v.exp_lo);
      if (v.lat != 0) begin
         step();
         check({v.name, "_done_width"}, {31'b0, done}, 32'd0);
      end
   endtask

   task automatic add_vec(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] mh, input logic [31:0] ml,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
      vec_t v;
      v.name = name; v.op = o; v.a = a; v.b = b; v.mh = mh; v.ml = ml;
      v.exp_hi = eh; v.exp_lo = el; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Reference: truncating division on 64-bit values, results cut to 32 bits.
   task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
      end
   endtask

   logic [31:0] hi_m;
   logic [31:0] lo_m;

   initial begin
      int          done_seen;
      vec_t        v;
      logic [31:0] q, r;

      total    = 0;
      bad      = 0;
      start    = 1'b0;
      op       = 3'b000;
      operandA = '0;
      operandB = '0;
      multHigh = '0;
      multLow  = '0;
      flush    = 1'b0;
      resetN   = 1'b1;

      // ---------------- reset state ----------------
      #1 resetN = 1'b0;
      #2;
      check("reset_hi",   hi, 32'd0);
      check("reset_lo",   lo, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      repeat (2) @(posedge clock);
      #1 resetN = 1'b1;

      // ---------------- directed table ----------------
      add_vec("mult_neg6",   OP_MULT,  0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
      add_vec("multu",       OP_MULTU, 0, 0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 0);
      add_vec("mthi",        OP_MTHI,  32'hDEAD, 0, 32'h55, 32'h66, 32'hDEAD, 32'h0000_0002, 0);
      add_vec("mtlo",        OP_MTLO,  32'hBEEF, 0, 32'h55, 32'h66, 32'hDEAD, 32'hBEEF, 0);
      add_vec("nop110",      OP_NOP6,  32'h1, 32'h2, 32'h3, 32'h4, 32'hDEAD, 32'hBEEF, 0);
      add_vec("divu_100_7",  OP_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, DIV_LAT);
      add_vec("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      add_vec("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000, DIV_LAT);
      add_vec("divu_5_0",    OP_DIVU,  32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFF_FFFF, 1);
      add_vec("div_7_m2",    OP_DIV,   32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
      add_vec("div_m8_2",    OP_DIV,   32'hFFFF_FFF8, 32'd2, 0, 0, 32'd0, 32'hFFFF_FFFC, DIV_LAT);
      add_vec("divu_max_1",  OP_DIVU,  32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
      add_vec("div_m5_0",    OP_DIV,   32'hFFFF_FFFB, 32'd0, 0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
      foreach (vecs[i]) apply(vecs[i]);

      // ---------------- back-to-back: new DIV issued in the done cycle ----------------
      issue(OP_DIVU, 32'd100, 32'd7, 0, 0, 1'b0);
      wait_done("b2b_first", DIV_LAT);
      check("b2b_first_lo", lo, 32'd14);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
      wait_done("b2b_second", DIV_LAT);
      check("b2b_second_hi", hi, 32'hFFFF_FFFF);
      check("b2b_second_lo", lo, 32'hFFFF_FFFD);

      // ---------------- MTLO ignored while busy, then flush mid-divide ----------------
      issue(OP_MTHI, 32'h1111, 0, 0, 0, 1'b0);
      issue(OP_MTLO, 32'h2222, 0, 0, 0, 1'b0);
      issue(OP_DIV, 32'd1000, 32'd3, 0, 0, 1'b0);
      for (int c = 1; c < 20; c++) begin
         start    = (c == 10);
         op       = OP_MTLO;
         operandA = 32'h1234;
         step();
      end
      start = 1'b0;
      check("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_done", {31'b0, done}, 32'd0);
      check("flush_hi", hi, 32'h1111);
      check("flush_lo", lo, 32'h2222);
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         step();
      end
      check("flush_no_done_later", done_seen, 0);
      issue(OP_MTHI, 32'hABCD, 0, 0, 0, 1'b0);
      check("post_flush_mthi_hi", hi, 32'hABCD);
      check("post_flush_mthi_lo", lo, 32'h2222);

      // ---------------- flush wins over FIXUP completion ----------------
      issue(OP_MTHI, 32'h77, 0, 0, 0, 1'b0);
      issue(OP_MTLO, 32'h88, 0, 0, 0, 1'b0);
      issue(OP_DIVU, 32'd50, 32'd5, 0, 0, 1'b0);
      repeat (32) step();
      check("fixflush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fixflush_done", {31'b0, done}, 32'd0);
      check("fixflush_busy", {31'b0, busy}, 32'd0);
      check("fixflush_hi", hi, 32'h77);
      check("fixflush_lo", lo, 32'h88);
      step();
      check("fixflush_done_later", {31'b0, done}, 32'd0);

      // ---------------- start and flush together in IDLE: start wins ----------------
      issue(OP_MTHI, 32'h4242, 0, 0, 0, 1'b1);
      check("idle_flush_mthi_hi", hi, 32'h4242);
      issue(OP_DIVU, 32'd21, 32'd4, 0, 0, 1'b1);
      wait_done("idle_flush_divu", DIV_LAT);
      check("idle_flush_divu_hi", hi, 32'd1);
      check("idle_flush_divu_lo", lo, 32'd5);

      // ---------------- async reset mid-divide ----------------
      issue(OP_MTHI, 32'h55, 0, 0, 0, 1'b0);
      issue(OP_MTLO, 32'h66, 0, 0, 0, 1'b0);
      issue(OP_DIVU, 32'd1000, 32'd7, 0, 0, 1'b0);
      repeat (5) step();
      check("areset_busy_before", {31'b0, busy}, 32'd1);
      #2 resetN = 1'b0;
      #1;
      check("areset_hi",   hi, 32'd0);
      check("areset_lo",   lo, 32'd0);
      check("areset_busy", {31'b0, busy}, 32'd0);
      check("areset_done", {31'b0, done}, 32'd0);
      @(posedge clock);
      #1 resetN = 1'b1;
      add_vec("after_reset_divu_9_3", OP_DIVU, 32'd9, 32'd3, 0, 0, 32'd0, 32'd3, DIV_LAT);
      apply(vecs[vecs.size()-1]);

      // ---------------- randomized run against the reference model ----------------
      hi_m = 32'd0;
      lo_m = 32'd3;
      for (int i = 0; i < 40; i++) begin
         v.name = $sformatf("rand%0d", i);
         v.op   = 3'($urandom_range(0, 7));
         v.a    = $urandom;
         case ($urandom_range(0, 7))
            0:       v.b = 32'd0;
            1, 2:    v.b = $urandom_range(1, 20);
            3:       v.b = -$urandom_range(1, 20);
            default: v.b = $urandom;
         endcase
         v.mh  = $urandom;
         v.ml  = $urandom;
         v.lat = 0;
         case (v.op)
            OP_MULT, OP_MULTU: begin
               hi_m = v.mh;
               lo_m = v.ml;
            end
            OP_MTHI: hi_m = v.a;
            OP_MTLO: lo_m = v.a;
            OP_DIV, OP_DIVU: begin
               ref_div(v.op == OP_DIV, v.a, v.b, q, r);
               lo_m  = q;
               hi_m  = r;
               v.lat = (v.b == 32'd0) ? 1 : DIV_LAT;
            end
            default: ;
         endcase
         v.exp_hi = hi_m;
         v.exp_lo = lo_m;
         apply(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
